// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with runtime baud divisor, parity and stop-bit
// selection, feeding a first-word-fall-through receive FIFO.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rx_serial_in           asynchronous serial line (idle high)
//   clks_per_bit_in        clk cycles per bit (clamped to >= 4)
//   parity_mode_in         00/11 none, 01 even, 10 odd
//   two_stop_in            1 selects two stop bits
//   rd_en_in               pop FIFO head
//   clr_overrun_in         clear sticky overrun flag
//   rx_data_out, rx_parity_err_out, rx_frame_err_out   FIFO head entry
//   rx_valid_out, rx_level_out                        FIFO status
//   rx_overrun_out         sticky: a frame was dropped on a full FIFO
//   rx_done_out            one-cycle pulse per completed frame
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx_serial_in,
  input  logic [DIV_WIDTH-1:0]               clks_per_bit_in,
  input  logic [1:0]                         parity_mode_in,
  input  logic                               two_stop_in,
  input  logic                               rd_en_in,
  input  logic                               clr_overrun_in,
  output logic [DATA_BITS-1:0]               rx_data_out,
  output logic                               rx_parity_err_out,
  output logic                               rx_frame_err_out,
  output logic                               rx_valid_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_level_out,
  output logic                               rx_overrun_out,
  output logic                               rx_done_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = DATA_BITS + 2;
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state, state_n;
  logic                 rx_s1, rx_s2;
  logic [DIV_WIDTH-1:0] cnt, cnt_n, div_l, div_n, div_eff;
  logic [1:0]           pm_l, pm_n;
  logic                 two_l, two_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic [BW-1:0]        bit_idx, idx_n;
  logic                 perr, perr_n, ferr, ferr_n, stop2, stop2_n;
  logic                 tick, par_en, ferr_fin, push_c;
  logic [EW-1:0]        entry_c;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wptr, rptr;
  logic                 full_c, empty_c, pop_c, wr_c;
  logic [EW-1:0]        head_c;

  // Clamp the divisor so the mid-bit offset and reload values stay sane
  assign div_eff = (clks_per_bit_in < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : clks_per_bit_in;
  assign tick    = (cnt == '0);
  assign par_en  = (pm_l == 2'b01) || (pm_l == 2'b10);

  // Frame decoder: next-state and datapath updates
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div_l;
    pm_n     = pm_l;
    two_n    = two_l;
    sh_n     = shreg;
    idx_n    = bit_idx;
    perr_n   = perr;
    ferr_n   = ferr;
    stop2_n  = stop2;
    push_c   = 1'b0;
    ferr_fin = ferr | ~rx_s2;
    entry_c  = {ferr_fin, perr, shreg};
    case (state)
      S_IDLE: begin
        if (!rx_s2) begin
          div_n   = div_eff;
          pm_n    = parity_mode_in;
          two_n   = two_stop_in;
          cnt_n   = (div_eff - DIV_WIDTH'(1)) >> 1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end else if (rx_s2) begin
          state_n = S_IDLE;
        end else begin
          cnt_n   = div_l - DIV_WIDTH'(1);
          idx_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          stop2_n = 1'b0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end else begin
          sh_n  = {rx_s2, shreg[DATA_BITS-1:1]};
          cnt_n = div_l - DIV_WIDTH'(1);
          idx_n = bit_idx + BW'(1);
          if (bit_idx == BW'(DATA_BITS - 1))
            state_n = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (!tick) begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end else begin
          // Odd mode inverts the even-mode error term
          perr_n  = (^shreg) ^ rx_s2 ^ (pm_l == 2'b10);
          cnt_n   = div_l - DIV_WIDTH'(1);
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end else if (two_l && !stop2) begin
          ferr_n  = ~rx_s2;
          stop2_n = 1'b1;
          cnt_n   = div_l - DIV_WIDTH'(1);
        end else begin
          ferr_n  = ferr_fin;
          push_c  = 1'b1;
          // A line still low after a framing error is a break; wait it out
          state_n = (ferr_fin && !rx_s2) ? S_WAIT_HIGH : S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s2) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Synchroniser and decoder registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      div_l   <= DIV_WIDTH'(4);
      pm_l    <= 2'b00;
      two_l   <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      stop2   <= 1'b0;
    end else begin
      rx_s1   <= rx_serial_in;
      rx_s2   <= rx_s1;
      state   <= state_n;
      cnt     <= cnt_n;
      div_l   <= div_n;
      pm_l    <= pm_n;
      two_l   <= two_n;
      shreg   <= sh_n;
      bit_idx <= idx_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
      stop2   <= stop2_n;
    end
  end

  assign empty_c = (wptr == rptr);
  assign full_c  = ((wptr - rptr) == PW'(FIFO_DEPTH));
  assign pop_c   = rd_en_in && !empty_c;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign wr_c    = push_c && (!full_c || pop_c);

  // Receive FIFO storage, pointers, overrun and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wptr           <= '0;
      rptr           <= '0;
      rx_overrun_out <= 1'b0;
      rx_done_out    <= 1'b0;
    end else begin
      if (wr_c) begin
        mem[wptr[AW-1:0]] <= entry_c;
        wptr              <= wptr + PW'(1);
      end
      if (pop_c) rptr <= rptr + PW'(1);
      rx_done_out <= push_c;
      if (push_c && !wr_c)  rx_overrun_out <= 1'b1;
      else if (clr_overrun_in) rx_overrun_out <= 1'b0;
    end
  end

  // Head is a read of registered storage at the registered read pointer
  assign head_c            = mem[rptr[AW-1:0]];
  assign rx_data_out       = head_c[DATA_BITS-1:0];
  assign rx_parity_err_out = head_c[DATA_BITS];
  assign rx_frame_err_out  = head_c[DATA_BITS+1];
  assign rx_valid_out      = !empty_c;
  assign rx_level_out      = LW'(wptr - rptr);

endmodule
